// File: rtl/recovery_sequencer_pkg.sv
// Shared definitions for the post-retire recovery sequencer.
//   XLEN                   : architectural PC width
//   SUPERSCALAR_WAYS       : retire width (one complete flag per way)
//   RECOVERY_FLUSH_CYCLES  : default number of cycles squash is held
//   RECOVERY_STATE         : sequencer FSM encoding, also exported for debug
package sys_defs;
  localparam int XLEN                  = 32;
  localparam int SUPERSCALAR_WAYS      = 3;
  localparam int RECOVERY_FLUSH_CYCLES = 1;

  typedef enum logic [2:0] {
    RS_IDLE      = 3'd0,
    RS_SQUASH    = 3'd1,
    RS_DRAIN     = 3'd2,
    RS_REDIRECT  = 3'd3,
    RS_HALT_WAIT = 3'd4,
    RS_HALTED    = 3'd5
  } RECOVERY_STATE;
endpackage

// File: rtl/recovery_sequencer_retire_counter.sv
// retire_counter: accumulates the number of instructions retired per cycle.
//   clock, reset_n : clock and asynchronous active-low reset
//   en             : count this cycle (sequencer idle, retire not stalled)
//   retire_valid   : per-way complete flags, counted as given
//   count          : running total, wraps modulo 2^CNT_W
module retire_counter
  import sys_defs::*;
#(
  parameter int CNT_W = 64
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        en,
  input  logic [SUPERSCALAR_WAYS-1:0] retire_valid,
  output logic [CNT_W-1:0]            count
);
  localparam int POP_W = $clog2(SUPERSCALAR_WAYS + 1);

  logic [POP_W-1:0] pop;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  always_comb begin
    pop = '0;
    for (int i = 0; i < SUPERSCALAR_WAYS; i++) begin
      pop = pop + POP_W'(retire_valid[i]);
    end
  end

  // Popcount is zero-extended; the sum wraps naturally at CNT_W bits.
  assign count_d = count_q + CNT_W'(pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/recovery_sequencer.sv
// recovery_sequencer: sequences precise-state recovery and halt after retire.
// Inputs (from retire / memory system):
//   br_recover_enable, target_pc : mispredict event and correct-path PC
//   wfi_halt                     : halt instruction retired this cycle
//   retire_valid                 : per-way complete flags
//   sq_empty, dcache_busy        : store queue drained / D-cache traffic pending
// Outputs (all registered):
//   squash, maptable_restore     : flush speculative state / restore rename map
//   fetch_redirect, redirect_pc  : one-cycle strobe to fetch; pc valid with strobe
//   retire_stall                 : high in every state except IDLE
//   halted                       : sticky until reset
//   retired_cnt                  : total retired instructions
//   state_dbg                    : current FSM state
// Interface note: there is no valid/ready handshake here. Events are only
// sampled in IDLE; in every other state retire is stalled, so events arriving
// then are ignored. fetch_redirect is a single-cycle strobe that fetch must
// accept unconditionally.
module recovery_sequencer
  import sys_defs::*;
#(
  parameter int FLUSH_CYCLES = RECOVERY_FLUSH_CYCLES,
  parameter int CNT_W        = 64
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        br_recover_enable,
  input  logic [XLEN-1:0]             target_pc,
  input  logic                        wfi_halt,
  input  logic [SUPERSCALAR_WAYS-1:0] retire_valid,
  input  logic                        sq_empty,
  input  logic                        dcache_busy,
  output logic                        squash,
  output logic                        maptable_restore,
  output logic                        fetch_redirect,
  output logic [XLEN-1:0]             redirect_pc,
  output logic                        retire_stall,
  output logic                        halted,
  output logic [CNT_W-1:0]            retired_cnt,
  output RECOVERY_STATE               state_dbg
);
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  RECOVERY_STATE   state_q;
  logic [FC_W-1:0] flush_cnt_q;
  logic            squash_q;
  logic            maptable_restore_q;
  logic            fetch_redirect_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic            retire_stall_q;
  logic            halted_q;

  // Outputs are written on the transition into a state, so they are valid
  // during the first cycle of that state (e.g. squash the cycle after the event).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= RS_IDLE;
      flush_cnt_q        <= '0;
      squash_q           <= 1'b0;
      maptable_restore_q <= 1'b0;
      fetch_redirect_q   <= 1'b0;
      redirect_pc_q      <= '0;
      retire_stall_q     <= 1'b0;
      halted_q           <= 1'b0;
    end else begin
      // Single-cycle strobes.
      maptable_restore_q <= 1'b0;
      fetch_redirect_q   <= 1'b0;
      case (state_q)
        RS_IDLE: begin
          // Halt wins over a same-cycle recovery; the recovery is dropped.
          if (wfi_halt) begin
            state_q        <= RS_HALT_WAIT;
            retire_stall_q <= 1'b1;
          end else if (br_recover_enable) begin
            state_q            <= RS_SQUASH;
            redirect_pc_q      <= target_pc;
            flush_cnt_q        <= FC_W'(FLUSH_CYCLES - 1);
            squash_q           <= 1'b1;
            maptable_restore_q <= 1'b1;
            retire_stall_q     <= 1'b1;
          end
        end
        RS_SQUASH: begin
          if (flush_cnt_q == '0) begin
            squash_q <= 1'b0;
            // With no D-cache traffic, DRAIN is skipped so redirect follows
            // the last squash cycle directly.
            if (dcache_busy) begin
              state_q <= RS_DRAIN;
            end else begin
              state_q          <= RS_REDIRECT;
              fetch_redirect_q <= 1'b1;
            end
          end else begin
            flush_cnt_q <= flush_cnt_q - 1'b1;
          end
        end
        RS_DRAIN: begin
          if (!dcache_busy) begin
            state_q          <= RS_REDIRECT;
            fetch_redirect_q <= 1'b1;
          end
        end
        RS_REDIRECT: begin
          state_q        <= RS_IDLE;
          retire_stall_q <= 1'b0;
        end
        RS_HALT_WAIT: begin
          if (sq_empty) begin
            state_q  <= RS_HALTED;
            halted_q <= 1'b1;
          end
        end
        RS_HALTED: begin
          // Terminal until reset.
        end
        default: begin
          state_q        <= RS_IDLE;
          squash_q       <= 1'b0;
          retire_stall_q <= 1'b0;
        end
      endcase
    end
  end

  // The event-cycle group still retires, so counting keys off the current state.
  retire_counter #(
    .CNT_W(CNT_W)
  ) u_retire_counter (
    .clock       (clock),
    .reset_n     (reset_n),
    .en          (state_q == RS_IDLE),
    .retire_valid(retire_valid),
    .count       (retired_cnt)
  );

  assign squash           = squash_q;
  assign maptable_restore = maptable_restore_q;
  assign fetch_redirect   = fetch_redirect_q;
  assign redirect_pc      = redirect_pc_q;
  assign retire_stall     = retire_stall_q;
  assign halted           = halted_q;
  assign state_dbg        = state_q;
endmodule
